// File: rtl/arbitro_rr_mux.sv
// Round-robin arbiter for eight byte requesters with an 8:1 byte mux on the granted index.
// A grant is held for up to MAX_RAJADA transfers, then the requesters are re-arbitrated.
module arbitro_rr_mux #(
    parameter int MAX_RAJADA = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_req,
    input  logic [7:0] i_e0,
    input  logic [7:0] i_e1,
    input  logic [7:0] i_e2,
    input  logic [7:0] i_e3,
    input  logic [7:0] i_e4,
    input  logic [7:0] i_e5,
    input  logic [7:0] i_e6,
    input  logic [7:0] i_e7,
    input  logic       i_pronto,
    output logic [7:0] o_concessao,
    output logic [2:0] o_sinal,
    output logic [7:0] o_saida,
    output logic       o_valida
);
    // state  | meaning
    // OCIOSO | no grant, Valida low
    // ATIVO  | grant held on r_sinal, Valida high
    typedef enum logic {OCIOSO = 1'b0, ATIVO = 1'b1} t_estado;

    t_estado    r_estado, w_estado;
    logic [2:0] r_ponteiro, w_ponteiro;
    logic [2:0] r_sinal, w_sinal;
    logic [3:0] r_contagem, w_contagem;
    logic [7:0] r_concessao, w_concessao;
    logic       r_valida, w_valida;
    logic [4:0] w_cont_inc;
    logic [2:0] w_ptr_lib;
    logic [2:0] w_escolha;
    logic [7:0] w_bytes [8];

    // First requester at or after ptr, wrapping 7 -> 0; lowest offset wins.
    function automatic logic [2:0] f_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] res;
        res = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) res = idx;
        end
        return res;
    endfunction

    always_comb begin
        w_estado    = r_estado;
        w_ponteiro  = r_ponteiro;
        w_sinal     = r_sinal;
        w_contagem  = r_contagem;
        w_concessao = r_concessao;
        w_valida    = r_valida;
        w_cont_inc  = {1'b0, r_contagem} + 5'd1;
        w_ptr_lib   = r_sinal + 3'd1;
        w_escolha   = '0;
        case (r_estado)
            OCIOSO: begin
                w_valida    = 1'b0;
                w_concessao = 8'h00;
                if (|i_req) begin
                    w_escolha   = f_pick(i_req, r_ponteiro);
                    w_sinal     = w_escolha;
                    w_contagem  = 4'd0;
                    w_valida    = 1'b1;
                    w_concessao = 8'd1 << w_escolha;
                    w_estado    = ATIVO;
                end
            end
            ATIVO: begin
                if (i_pronto) begin
                    if (i_req[r_sinal] && (w_cont_inc < 5'(MAX_RAJADA))) begin
                        w_contagem = w_cont_inc[3:0];
                    end else begin
                        // A sole requester still asserting is found again after the wrap.
                        w_ponteiro = w_ptr_lib;
                        w_contagem = 4'd0;
                        if (|i_req) begin
                            w_escolha   = f_pick(i_req, w_ptr_lib);
                            w_sinal     = w_escolha;
                            w_concessao = 8'd1 << w_escolha;
                            w_valida    = 1'b1;
                        end else begin
                            w_estado    = OCIOSO;
                            w_valida    = 1'b0;
                            w_concessao = 8'h00;
                        end
                    end
                end
            end
            default: w_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado    <= OCIOSO;
            r_ponteiro  <= 3'd0;
            r_sinal     <= 3'd0;
            r_contagem  <= 4'd0;
            r_concessao <= 8'h00;
            r_valida    <= 1'b0;
        end else begin
            r_estado    <= w_estado;
            r_ponteiro  <= w_ponteiro;
            r_sinal     <= w_sinal;
            r_contagem  <= w_contagem;
            r_concessao <= w_concessao;
            r_valida    <= w_valida;
        end
    end

    always_comb begin
        w_bytes[0] = i_e0;
        w_bytes[1] = i_e1;
        w_bytes[2] = i_e2;
        w_bytes[3] = i_e3;
        w_bytes[4] = i_e4;
        w_bytes[5] = i_e5;
        w_bytes[6] = i_e6;
        w_bytes[7] = i_e7;
    end

    assign o_saida     = w_bytes[r_sinal];
    assign o_sinal     = r_sinal;
    assign o_concessao = r_concessao;
    assign o_valida    = r_valida;
endmodule

// File: tb/tb_arbitro_rr_mux.sv
// Directed bench for arbitro_rr_mux: one instance at MAX_RAJADA=4, one at MAX_RAJADA=1.
module tb_arbitro_rr_mux;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       pronto;
    logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7;
    logic [7:0] conc, saida, conc1, saida1;
    logic [2:0] sinal, sinal1;
    logic       valida, valida1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    arbitro_rr_mux #(.MAX_RAJADA(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_req(req),
        .i_e0(e0), .i_e1(e1), .i_e2(e2), .i_e3(e3),
        .i_e4(e4), .i_e5(e5), .i_e6(e6), .i_e7(e7),
        .i_pronto(pronto), .o_concessao(conc), .o_sinal(sinal),
        .o_saida(saida), .o_valida(valida));

    arbitro_rr_mux #(.MAX_RAJADA(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_req(req),
        .i_e0(e0), .i_e1(e1), .i_e2(e2), .i_e3(e3),
        .i_e4(e4), .i_e5(e5), .i_e6(e6), .i_e7(e7),
        .i_pronto(pronto), .o_concessao(conc1), .o_sinal(sinal1),
        .o_saida(saida1), .o_valida(valida1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        pronto = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; pronto = 1'b1;
        tick();
        n_cmp++; if (valida !== 1'b0) begin n_err++; $display("FAIL reset_valida got %b want 0", valida); end
        n_cmp++; if (conc !== 8'h00) begin n_err++; $display("FAIL reset_conc got %h want 00", conc); end
        n_cmp++; if (sinal !== 3'd0) begin n_err++; $display("FAIL reset_sinal got %0d want 0", sinal); end
        rst = 1'b0; req = 8'h00; pronto = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if (valida !== 1'b0 || conc !== 8'h00) begin
                n_err++; $display("FAIL idle_cycle%0d got valida=%b conc=%h want 0/00", c, valida, conc);
            end
        end
    endtask

    task automatic test_burst();
        logic [2:0] exp_s [12] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5,
                                   3'd2, 3'd2, 3'd2, 3'd2};
        logic [7:0] exp_d [12] = '{8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                                   8'hA2, 8'hA2, 8'hA2, 8'hA2};
        logic [7:0] exp_c [12] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h20, 8'h20, 8'h20, 8'h20,
                                   8'h04, 8'h04, 8'h04, 8'h04};
        do_reset();
        req = 8'b0010_0100; pronto = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++; if (valida !== 1'b1 || sinal !== exp_s[k] || saida !== exp_d[k] || conc !== exp_c[k]) begin
                n_err++;
                $display("FAIL burst_edge%0d got valida=%b sinal=%0d saida=%h conc=%h want 1/%0d/%h/%h",
                         k + 1, valida, sinal, saida, conc, exp_s[k], exp_d[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 8'h08; pronto = 1'b0;
        tick();
        req = 8'h00;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (valida !== 1'b1 || sinal !== 3'd3 || conc !== 8'h08 || saida !== 8'hA3) begin
                n_err++;
                $display("FAIL stall_cycle%0d got valida=%b sinal=%0d conc=%h saida=%h want 1/3/08/a3",
                         c, valida, sinal, conc, saida);
            end
        end
        pronto = 1'b1;
        tick();
        n_cmp++; if (valida !== 1'b0 || conc !== 8'h00 || sinal !== 3'd3) begin
            n_err++; $display("FAIL stall_release got valida=%b conc=%h sinal=%0d want 0/00/3", valida, conc, sinal);
        end
    endtask

    task automatic test_wrap_max1();
        logic [2:0] exp_s [4] = '{3'd0, 3'd7, 3'd0, 3'd7};
        do_reset();
        req = 8'h81; pronto = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (valida1 !== 1'b1 || sinal1 !== exp_s[k] || conc1 !== (8'd1 << exp_s[k])) begin
                n_err++;
                $display("FAIL wrap_edge%0d got valida=%b sinal=%0d conc=%h want 1/%0d", k + 1, valida1, sinal1, conc1, exp_s[k]);
            end
        end
    endtask

    task automatic test_back_to_back_sole();
        do_reset();
        req = 8'h08; pronto = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++; if (valida !== 1'b1 || sinal !== 3'd3 || conc !== 8'h08) begin
                n_err++; $display("FAIL sole_xfer%0d got valida=%b sinal=%0d conc=%h want 1/3/08", k + 1, valida, sinal, conc);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h20; pronto = 1'b0;
        tick();
        n_cmp++; if (sinal !== 3'd5 || valida !== 1'b1) begin
            n_err++; $display("FAIL mid_grant got sinal=%0d valida=%b want 5/1", sinal, valida);
        end
        req = 8'h21; pronto = 1'b1; rst = 1'b1;
        tick();
        n_cmp++; if (valida !== 1'b0 || conc !== 8'h00 || sinal !== 3'd0) begin
            n_err++; $display("FAIL mid_reset got valida=%b conc=%h sinal=%0d want 0/00/0", valida, conc, sinal);
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (valida !== 1'b1 || sinal !== 3'd0 || conc !== 8'h01) begin
            n_err++; $display("FAIL post_reset_grant got valida=%b sinal=%0d conc=%h want 1/0/01", valida, sinal, conc);
        end
        // Four transfers on requester 0, counted from zero, then rotation to 5.
        for (int k = 0; k < 3; k++) tick();
        n_cmp++; if (sinal !== 3'd0) begin
            n_err++; $display("FAIL post_reset_hold got sinal=%0d want 0", sinal);
        end
        tick();
        n_cmp++; if (sinal !== 3'd5 || valida !== 1'b1) begin
            n_err++; $display("FAIL post_reset_rotate got sinal=%0d valida=%b want 5/1", sinal, valida);
        end
    endtask

    initial begin
        e0 = 8'hA0; e1 = 8'hA1; e2 = 8'hA2; e3 = 8'hA3;
        e4 = 8'hA4; e5 = 8'hA5; e6 = 8'hA6; e7 = 8'hA7;
        rst = 1'b1; req = 8'h00; pronto = 1'b0;
        test_reset();
        test_burst();
        test_stall();
        test_wrap_max1();
        test_back_to_back_sole();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
